pwm_tb_ctrl: RTL and testbench
==============================

PWM_TB_CTRL -- requirements
Module: pwm_tb_ctrl

Interface
REQ-001 Parameter WIDTH, 17, total compare width in fine steps (coarse + HR bits).
REQ-002 Parameter HRBITS, 3, high-resolution sub-cycle bits; CW = WIDTH-HRBITS coarse width.
REQ-003 clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-004 enable  in  1  run request; low holds timebase idle.
REQ-005 period  in  CW  last coarse count of a PWM period (period length = period+1 cycles).
REQ-006 cmd_valid  in  1 / cmd_ready  out  1  compare-update handshake.
REQ-007 cmd_cmpL, cmd_cmpH  in  WIDTH each  requested falling/rising edge positions.
REQ-008 tb  out  CW  coarse timebase feeding the downstream output-compare stage.
REQ-009 cmpL, cmpH  out  WIDTH each  active compare values for the output-compare stage.
REQ-010 wrap  out  1  one-cycle pulse on every period start; cmd_err  out  1  one-cycle reject pulse.

Function
REQ-011 States IDLE and RUN; IDLE->RUN when enable=1, RUN->IDLE when enable=0, both effective at next clk edge.
REQ-012 In IDLE, tb shall be 0 and wrap 0.
REQ-013 A "wrap event" is the IDLE->RUN edge, or the RUN-state edge where tb==period_q.
REQ-014 In RUN, tb increments by 1 per cycle; at a wrap event tb becomes 0.
REQ-015 period is sampled into period_q only at a wrap event; period=0 gives tb constantly 0 and wrap every cycle.
REQ-016 wrap is registered, asserted the cycle tb==0 after a wrap event.
REQ-017 cmd_ready = shadow-empty; transfer occurs on cmd_valid && cmd_ready at clk edge, filling the shadow.
REQ-018 A command whose cmd_cmpL or cmd_cmpH coarse part [WIDTH-1:HRBITS] exceeds period (the live input) is accepted but discarded: shadow stays empty, cmd_err pulses next cycle.
REQ-019 At a wrap event a full shadow is copied to cmpL/cmpH and emptied, so new values appear together with tb==0; cmpL and cmpH never change at any other edge.
REQ-020 A command accepted on the same edge as a wrap event goes to the shadow and applies at the following wrap event.
REQ-021 Shadow contents survive RUN->IDLE and apply at the next IDLE->RUN edge.
REQ-022 A second command while shadow full is stalled by cmd_ready=0; cmd_* must be held stable while cmd_valid=1 and cmd_ready=0.

Reset
REQ-023 rst asserted: state IDLE, tb=0, period_q=0, cmpL=0, cmpH=0, shadow empty, cmd_ready=1, wrap=0, cmd_err=0.
REQ-024 rst mid-period or mid-handshake discards pending shadow and returns all outputs to REQ-023 values immediately.

Configuration
REQ-025 Macro PWM_TB_SYNC_EN: when defined, add input sync_in (1 bit, asynchronous); two-flop synchronize it, and a synchronized rising edge in RUN forces a wrap event on the following edge regardless of tb.
REQ-026 Without PWM_TB_SYNC_EN, no sync_in port exists and wraps occur only per REQ-013.

Structure
REQ-027 Shared package pwm_pkg holds WIDTH/HRBITS defaults, CW derivation and the IDLE/RUN state enum.
REQ-028 One sub-module pwm_cmp_shadow (shadow register, handshake, range check, load-on-wrap); counter/FSM stays in the top.

Verification
REQ-029 period=9, enable rises: tb 0..9 repeating, wrap every 10 cycles, first wrap the cycle after enable edge.
REQ-030 Mid-period, cmd cmpH=0x10 (coarse 2), cmpL=0x2C (coarse 5): cmd_ready drops, cmpL/cmpH unchanged until tb returns to 0, then both update same cycle, cmd_ready back to 1.
REQ-031 period=9, cmd cmpH coarse=12: cmd_err pulses once, shadow empty, active compares unchanged.
REQ-032 Command accepted on the tb==9 edge: applied at the next wrap (10 cycles later), not the current one.
REQ-033 period changed 9->4 mid-period: current period completes at tb=9, next period runs tb 0..4.
REQ-034 rst pulsed with full shadow at tb=6: tb=0, cmpL=cmpH=0, cmd_ready=1 immediately; with PWM_TB_SYNC_EN, sync_in edge at tb=3 yields tb=0 three clocks later (2-flop sync + 1).

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared defaults and state encoding for the PWM timebase controller.
package pwm_pkg;
  localparam int WIDTH_DEF  = 17;
  localparam int HRBITS_DEF = 3;
  localparam int CW_DEF     = WIDTH_DEF - HRBITS_DEF;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic int coarse_w(input int width, input int hrbits);
    return width - hrbits;
  endfunction
endpackage

// File: rtl/pwm_cmp_shadow.sv
// Compare shadow register: handshake, coarse range check against the live
// period, and atomic copy into the active compares on every wrap event.
import pwm_pkg::*;

module pwm_cmp_shadow #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HRBITS = HRBITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wrap_ev,
  input  logic [WIDTH-HRBITS-1:0]   period,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [WIDTH-1:0]          cmd_cmpL,
  input  logic [WIDTH-1:0]          cmd_cmpH,
  output logic [WIDTH-1:0]          cmpL,
  output logic [WIDTH-1:0]          cmpH,
  output logic                      cmd_err
);
  logic             full;
  logic [WIDTH-1:0] sh_l, sh_h;
  logic             accept, bad;

  assign cmd_ready = ~full;
  assign accept    = cmd_valid & ~full;
  // Range check uses the live period input, not the latched one.
  assign bad       = (cmd_cmpL[WIDTH-1:HRBITS] > period) ||
                     (cmd_cmpH[WIDTH-1:HRBITS] > period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      sh_l    <= '0;
      sh_h    <= '0;
      cmpL    <= '0;
      cmpH    <= '0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= accept & bad;
      // A full shadow blocks accept, so drain and fill never collide.
      if (wrap_ev && full) begin
        cmpL <= sh_l;
        cmpH <= sh_h;
        full <= 1'b0;
      end else if (accept && !bad) begin
        sh_l <= cmd_cmpL;
        sh_h <= cmd_cmpH;
        full <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/pwm_tb_ctrl.sv
// PWM coarse timebase with IDLE/RUN control and shadowed compare updates.
// Optional macro PWM_TB_SYNC_EN adds a synchronized external sync_in wrap.
import pwm_pkg::*;

module pwm_tb_ctrl #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HRBITS = HRBITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef PWM_TB_SYNC_EN
  input  logic                      sync_in,
`endif
  input  logic                      enable,
  input  logic [WIDTH-HRBITS-1:0]   period,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [WIDTH-1:0]          cmd_cmpL,
  input  logic [WIDTH-1:0]          cmd_cmpH,
  output logic [WIDTH-HRBITS-1:0]   tb,
  output logic [WIDTH-1:0]          cmpL,
  output logic [WIDTH-1:0]          cmpH,
  output logic                      wrap,
  output logic                      cmd_err
);
  localparam int CW = WIDTH - HRBITS;

  state_t        state_q, state_d;
  logic [CW-1:0] tb_q, tb_d, period_q;
  logic          wrap_ev, sync_rise;

`ifdef PWM_TB_SYNC_EN
  // Two flops of synchronization plus one for edge detection.
  logic [2:0] sync_pipe;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[1:0], sync_in};
  end
  assign sync_rise = sync_pipe[1] & ~sync_pipe[2];
`else
  assign sync_rise = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wrap_ev = 1'b0;
    tb_d    = '0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          wrap_ev = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tb_q == period_q || sync_rise) begin
          wrap_ev = 1'b1;
        end else begin
          tb_d = tb_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_q     <= '0;
      period_q <= '0;
      wrap     <= 1'b0;
    end else begin
      tb_q <= tb_d;
      wrap <= wrap_ev;
      if (wrap_ev) period_q <= period;
    end
  end

  assign tb = tb_q;

  pwm_cmp_shadow #(.WIDTH(WIDTH), .HRBITS(HRBITS)) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wrap_ev   (wrap_ev),
    .period    (period),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_cmpL  (cmd_cmpL),
    .cmd_cmpH  (cmd_cmpH),
    .cmpL      (cmpL),
    .cmpH      (cmpH),
    .cmd_err   (cmd_err)
  );
endmodule

// File: tb/tb_pwm_tb_ctrl.sv
// Directed bench for pwm_tb_ctrl: timebase, shadow handshake, range reject, reset.
module tb_pwm_tb_ctrl;
  localparam int WIDTH  = 17;
  localparam int HRBITS = 3;
  localparam int CW     = WIDTH - HRBITS;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [CW-1:0]    period;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_cmpL, cmd_cmpH;
  logic [CW-1:0]    tb;
  logic [WIDTH-1:0] cmpL, cmpH;
  logic             wrap, cmd_err;
`ifdef PWM_TB_SYNC_EN
  logic             sync_in;
`endif

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  pwm_tb_ctrl #(.WIDTH(WIDTH), .HRBITS(HRBITS)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PWM_TB_SYNC_EN
    .sync_in   (sync_in),
`endif
    .enable    (enable),
    .period    (period),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_cmpL  (cmd_cmpL),
    .cmd_cmpH  (cmd_cmpH),
    .tb        (tb),
    .cmpL      (cmpL),
    .cmpH      (cmpH),
    .wrap      (wrap),
    .cmd_err   (cmd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] h);
    cmd_cmpL  = l;
    cmd_cmpH  = h;
    cmd_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; period = 14'd9;
    cmd_valid = 1'b0; cmd_cmpL = '0; cmd_cmpH = '0;
`ifdef PWM_TB_SYNC_EN
    sync_in = 1'b0;
`endif
    #12;
    chk("rst_tb",    tb,        0);
    chk("rst_cmpL",  cmpL,      0);
    chk("rst_cmpH",  cmpH,      0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_wrap",  wrap,      0);
    chk("rst_err",   cmd_err,   0);
    @(negedge clk);
    rst = 1'b0;
    step(2);
    chk("idle_tb",   tb,   0);
    chk("idle_wrap", wrap, 0);

    // Timebase 0..9, first wrap right after enable edge
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("run_tb",   tb,   k % 10);
      chk("run_wrap", wrap, (k % 10) == 0);
    end

    // Mid-period update applies together with tb==0
    step(4);
    chk("pre_cmd_tb", tb, 3);
    send(17'h2C, 17'h10);
    step(1);
    cmd_valid = 1'b0;
    chk("upd_ready0", cmd_ready, 0);
    chk("upd_cmpL_hold", cmpL, 0);
    step(5);
    chk("upd_tb9", tb, 9);
    chk("upd_cmpH_hold", cmpH, 0);
    step(1);
    chk("upd_tb0",   tb,   0);
    chk("upd_wrap",  wrap, 1);
    chk("upd_cmpL",  cmpL, 17'h2C);
    chk("upd_cmpH",  cmpH, 17'h10);
    chk("upd_ready1", cmd_ready, 1);

    // Out-of-range coarse (12 > 9) rejected
    send(17'h08, 17'h60);
    step(1);
    cmd_valid = 1'b0;
    chk("rej_err",   cmd_err,   1);
    chk("rej_ready", cmd_ready, 1);
    step(1);
    chk("rej_err_clr", cmd_err, 0);
    chk("rej_cmpL",  cmpL, 17'h2C);
    chk("rej_cmpH",  cmpH, 17'h10);

    // Command on tb==9 edge waits for the following wrap
    step(7);
    chk("late_tb9", tb, 9);
    send(17'h18, 17'h09);
    step(1);
    cmd_valid = 1'b0;
    chk("late_wrap1", wrap, 1);
    chk("late_cmpL_old", cmpL, 17'h2C);
    chk("late_ready0", cmd_ready, 0);
    step(9);
    chk("late_tb9b", tb, 9);
    chk("late_cmpH_old", cmpH, 17'h10);
    step(1);
    chk("late_cmpL", cmpL, 17'h18);
    chk("late_cmpH", cmpH, 17'h09);

    // Period 9->4 mid-period
    step(3);
    period = 14'd4;
    step(6);
    chk("per_tb9", tb, 9);
    step(1);
    chk("per_tb0", tb, 0);
    step(4);
    chk("per_tb4", tb, 4);
    step(1);
    chk("per_wrap4", wrap, 1);
    chk("per_tb0b", tb, 0);

    // Back to 9, fill shadow, reset at tb=6
    period = 14'd9;
    step(4);
    step(1);
    chk("p9_wrap", wrap, 1);
    send(17'h20, 17'h08);
    step(1);
    cmd_valid = 1'b0;
    chk("r_ready0", cmd_ready, 0);
    step(5);
    chk("r_tb6", tb, 6);
    rst = 1'b1;
    #1;
    chk("r_tb",    tb,        0);
    chk("r_cmpL",  cmpL,      0);
    chk("r_cmpH",  cmpH,      0);
    chk("r_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    chk("r_wrap", wrap, 1);
    chk("r_cmpL_kept0", cmpL, 0);
    step(10);
    chk("r_wrap2", wrap, 1);
    chk("r_cmpH_kept0", cmpH, 0);

    // Shadow survives RUN->IDLE and applies on re-enable
    step(2);
    send(17'h30, 17'h00);
    step(1);
    cmd_valid = 1'b0;
    enable = 1'b0;
    step(1);
    chk("idl_tb", tb, 0);
    chk("idl_wrap", wrap, 0);
    chk("idl_cmpL", cmpL, 0);
    step(1);
    enable = 1'b1;
    step(1);
    chk("ren_wrap", wrap, 1);
    chk("ren_cmpL", cmpL, 17'h30);
    chk("ren_ready", cmd_ready, 1);

    // period=0: tb stuck at 0, wrap every cycle
    period = 14'd0;
    step(10);
    chk("p0_first", wrap, 1);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("p0_tb", tb, 0);
      chk("p0_wrap", wrap, 1);
    end

`ifdef PWM_TB_SYNC_EN
    period = 14'd9;
    step(1);
    step(3);
    chk("sy_tb3", tb, 3);
    sync_in = 1'b1;
    step(1);
    chk("sy_tb4", tb, 4);
    step(1);
    chk("sy_tb5", tb, 5);
    step(1);
    chk("sy_tb0", tb, 0);
    chk("sy_wrap", wrap, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
